// File: rtl/rx_fe_dc_cal.sv
// RX frontend DC-offset calibration: clear, settle, average, write back.
// done rises SETTLE + 2^LOG2_N + 4 clk edges after the edge sampling start.
module rx_fe_dc_cal #(
  parameter int BASE   = 0,
  parameter int LOG2_N = 10,
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [23:0] i_in,
  input  logic [23:0] q_in,
  input  logic        host_stb,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_data,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        busy,
  output logic        done,
  output logic [23:0] dc_i,
  output logic [23:0] dc_q
);

  localparam int AW = 24 + LOG2_N;
  localparam int N  = 1 << LOG2_N;
  localparam logic [7:0] A_I = 8'(BASE + 3);
  localparam logic [7:0] A_Q = 8'(BASE + 4);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR_I, S_CLR_Q, S_SETTLE,
    S_ACCUM, S_WR_I, S_WR_Q, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   cnt;
  logic [AW-1:0] acc_i, acc_q;
  logic [AW-1:0] acc_i_nxt, acc_q_nxt;
  logic          last_sample;
  logic          ctrl_req;
  logic [7:0]    ctrl_addr;
  logic [31:0]   ctrl_data;
  logic [23:0]   corr_i, corr_q;

  function automatic logic [23:0] neg_sat(
    input logic [23:0] m
  );
    if (m == 24'h800000)
      return 24'h7fffff;
    return -m;
  endfunction

  assign acc_i_nxt = acc_i + {{LOG2_N{i_in[23]}}, i_in};
  assign acc_q_nxt = acc_q + {{LOG2_N{q_in[23]}}, q_in};
  assign last_sample = (cnt == 32'(N - 1));
  assign corr_i = neg_sat(dc_i);
  assign corr_q = neg_sat(dc_q);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // controller writes advance only in cycles the host leaves free
  always_comb begin
    state_nxt = state;
    ctrl_req  = 1'b0;
    ctrl_addr = 8'h00;
    ctrl_data = 32'h0;
    unique case (state)
      S_IDLE:
        if (start) state_nxt = S_CLR_I;
      S_CLR_I: begin
        ctrl_req  = 1'b1;
        ctrl_addr = A_I;
        if (!host_stb) state_nxt = S_CLR_Q;
      end
      S_CLR_Q: begin
        ctrl_req  = 1'b1;
        ctrl_addr = A_Q;
        if (!host_stb) state_nxt = S_SETTLE;
      end
      S_SETTLE:
        if (cnt == 32'(SETTLE - 1))
          state_nxt = S_ACCUM;
      S_ACCUM:
        if (run && last_sample)
          state_nxt = S_WR_I;
      S_WR_I: begin
        ctrl_req  = 1'b1;
        ctrl_addr = A_I;
        ctrl_data = {{8{corr_i[23]}}, corr_i};
        if (!host_stb) state_nxt = S_WR_Q;
      end
      S_WR_Q: begin
        ctrl_req  = 1'b1;
        ctrl_addr = A_Q;
        ctrl_data = {{8{corr_q[23]}}, corr_q};
        if (!host_stb) state_nxt = S_DONE;
      end
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      dc_i     <= '0;
      dc_q     <= '0;
      set_stb  <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
    end else begin
      state <= state_nxt;

      if (host_stb) begin
        set_stb  <= 1'b1;
        set_addr <= host_addr;
        set_data <= host_data;
      end else if (ctrl_req) begin
        set_stb  <= 1'b1;
        set_addr <= ctrl_addr;
        set_data <= ctrl_data;
      end else begin
        set_stb  <= 1'b0;
      end

      if (state != state_nxt)
        cnt <= '0;
      else if (state == S_SETTLE)
        cnt <= cnt + 32'd1;
      else if (state == S_ACCUM && run)
        cnt <= cnt + 32'd1;

      if (state == S_SETTLE) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (state == S_ACCUM && run) begin
        acc_i <= acc_i_nxt;
        acc_q <= acc_q_nxt;
      end

      // top 24 bits of the final sum are the floored mean
      if (state == S_ACCUM && run && last_sample) begin
        dc_i <= acc_i_nxt[AW-1 -: 24];
        dc_q <= acc_q_nxt[AW-1 -: 24];
      end
    end
  end

endmodule

// File: tb/tb_rx_fe_dc_cal.sv
// Directed bench for rx_fe_dc_cal (LOG2_N=4, SETTLE=4, BASE=0).
module tb_rx_fe_dc_cal;

  localparam int L = 4;
  localparam int S = 4;

  typedef struct {
    logic [23:0] ia, ib, qa, qb;
    bit          tog;
    logic [23:0] edi, edq;
    logic [31:0] ewi, ewq;
    int          lmin, lmax;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, run;
  logic [23:0] i_in, q_in;
  logic        host_stb;
  logic [7:0]  host_addr;
  logic [31:0] host_data;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        busy, done;
  logic [23:0] dc_i, dc_q;

  always #5 clk = ~clk;

  rx_fe_dc_cal #(.BASE(0), .LOG2_N(L), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .i_in(i_in), .q_in(q_in),
    .host_stb(host_stb), .host_addr(host_addr),
    .host_data(host_data),
    .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data),
    .busy(busy), .done(done), .dc_i(dc_i), .dc_q(dc_q)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ndone = 0;
  bit ph;
  vec_t cv;
  vec_t vt[4];
  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (set_stb) begin
      wa.push_back(set_addr);
      wd.push_back(set_data);
    end
    if (done) ndone++;
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (run) ph = ~ph;
    #1;
    start = 1'b0;
    if (cv.tog) run = ~run;
    i_in = ph ? cv.ib : cv.ia;
    q_in = ph ? cv.qb : cv.qa;
  endtask

  task automatic run_cal(input int vi, input int host_at,
                         input bit extra);
    int w0, d0, t0, lat, n, bb, lo, hi;
    bit got;
    logic [7:0]  ea[$];
    logic [31:0] ed[$];
    cv = vt[vi];
    run = 1'b1;
    ph = 1'b0;
    i_in = cv.ia;
    q_in = cv.qa;
    w0 = wa.size();
    d0 = ndone;
    bb = 0;
    got = 0;
    n = 0;
    lat = -1;
    start = 1'b1;
    step();
    t0 = cyc;
    while (!got && n < 300) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        lat = cyc - t0;
      end else begin
        if (!busy) bb++;
        step();
        host_stb = (cyc - t0 == host_at);
        if (extra && (cyc - t0 == 5 || cyc - t0 == 10))
          start = 1'b1;
      end
      n++;
    end
    host_stb = 1'b0;
    chk($sformatf("v%0d done_seen", vi), 32'(got), 32'd1);
    lo = cv.lmin + ((host_at >= 0) ? 1 : 0);
    hi = cv.lmax + ((host_at >= 0) ? 1 : 0);
    tests++;
    if (lat < lo || lat > hi) begin
      fails++;
      $display("FAIL v%0d latency: got %0d expected %0d..%0d",
               vi, lat, lo, hi);
    end
    repeat (4) step();
    @(negedge clk);
    chk($sformatf("v%0d busy_after", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d busy_hold", vi), 32'(bb), 32'd0);
    chk($sformatf("v%0d ndone", vi), 32'(ndone - d0), 32'd1);
    chk($sformatf("v%0d dc_i", vi), 32'(dc_i), 32'(cv.edi));
    chk($sformatf("v%0d dc_q", vi), 32'(dc_q), 32'(cv.edq));
    ea = '{8'h03, 8'h04};
    ed = '{32'h0, 32'h0};
    if (host_at >= 0) begin
      ea.push_back(8'h20);
      ed.push_back(32'hdeadbeef);
    end
    ea.push_back(8'h03);
    ed.push_back(cv.ewi);
    ea.push_back(8'h04);
    ed.push_back(cv.ewq);
    chk($sformatf("v%0d nwr", vi), 32'(wa.size() - w0),
        32'(ea.size()));
    for (int k = 0; k < ea.size(); k++) begin
      if (w0 + k < wa.size()) begin
        chk($sformatf("v%0d wr%0d addr", vi, k),
            32'(wa[w0 + k]), 32'(ea[k]));
        chk($sformatf("v%0d wr%0d data", vi, k),
            wd[w0 + k], ed[k]);
      end
    end
  endtask

  int w0, d0;

  initial begin
    vt[0] = '{24'h000100, 24'h000100, 24'hffff00, 24'hffff00, 1'b0,
              24'h000100, 24'hffff00, 32'hffffff00, 32'h00000100,
              24, 24};
    vt[1] = '{24'h000100, 24'h000100, 24'hffff00, 24'hffff00, 1'b1,
              24'h000100, 24'hffff00, 32'hffffff00, 32'h00000100,
              39, 40};
    vt[2] = '{24'h000003, 24'h000002, 24'h800000, 24'h800000, 1'b0,
              24'h000002, 24'h800000, 32'hfffffffe, 32'h007fffff,
              24, 24};
    vt[3] = '{24'hfffffd, 24'hfffffe, 24'h7fffff, 24'h7fffff, 1'b0,
              24'hfffffd, 24'h7fffff, 32'h00000003, 32'hff800001,
              24, 24};
    cv = vt[0];
    rst = 1'b1;
    start = 1'b0;
    run = 1'b0;
    ph = 1'b0;
    i_in = '0;
    q_in = '0;
    host_stb = 1'b0;
    host_addr = '0;
    host_data = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst set_stb", 32'(set_stb), 32'd0);
    chk("rst set_addr", 32'(set_addr), 32'd0);
    chk("rst set_data", set_data, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst dc_i", 32'(dc_i), 32'd0);
    chk("rst dc_q", 32'(dc_q), 32'd0);

    host_addr = 8'h55;
    host_data = 32'h12345678;
    host_stb = 1'b1;
    step();
    host_stb = 1'b0;
    @(negedge clk);
    chk("host stb", 32'(set_stb), 32'd1);
    chk("host addr", 32'(set_addr), 32'h55);
    chk("host data", set_data, 32'h12345678);
    step();
    @(negedge clk);
    chk("host stb off", 32'(set_stb), 32'd0);

    host_addr = 8'h20;
    host_data = 32'hdeadbeef;
    for (int v = 0; v < 4; v++)
      run_cal(v, -1, 1'b0);
    run_cal(0, 22, 1'b0);
    run_cal(0, -1, 1'b1);

    cv = vt[0];
    run = 1'b1;
    w0 = wa.size();
    d0 = ndone;
    start = 1'b1;
    step();
    repeat (11) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst set_stb", 32'(set_stb), 32'd0);
    chk("mid rst set_addr", 32'(set_addr), 32'd0);
    chk("mid rst set_data", set_data, 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst dc_i", 32'(dc_i), 32'd0);
    chk("mid rst dc_q", 32'(dc_q), 32'd0);
    repeat (40) step();
    @(negedge clk);
    chk("mid rst nwr", 32'(wa.size() - w0), 32'd2);
    chk("mid rst ndone", 32'(ndone - d0), 32'd0);
    chk("mid rst busy later", 32'(busy), 32'd0);
    run_cal(0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_fe_dc_cal.md
Name: rx_fe_dc_cal

Overview:
- Automatic DC-offset calibration sequencer for the RX frontend.
- On a start pulse it:
  - clears the frontend I/Q offset settings registers;
  - waits for the datapath to settle;
  - averages 2^LOG2_N output samples per channel;
  - writes the negated means back to the frontend offset registers over the settings bus.
- Sits between the host settings bus and the frontend, merging host writes and its own writes onto one registered settings bus.

Parameters:
- BASE, 0, frontend settings base address; I offset register at BASE+3, Q offset register at BASE+4.
- LOG2_N, 10, log2 of number of averaged samples (range 1..16).
- SETTLE, 16, clock cycles to wait after clearing offsets before accumulating (at least 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- start  in  1  single-cycle calibration request.
- run  in  1  frontend sample-valid/run; one sample per clk while high.
- i_in  in  24  frontend I output, signed two's complement.
- q_in  in  24  frontend Q output, signed two's complement.
- host_stb  in  1  host settings strobe.
- host_addr  in  8  host settings address.
- host_data  in  32  host settings data.
- set_stb  out  1  merged settings strobe to frontend.
- set_addr  out  8  merged settings address.
- set_data  out  32  merged settings data.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse on completion.
- dc_i  out  24  last measured I mean (signed).
- dc_q  out  24  last measured Q mean (signed).

Behaviour:
- Clock and reset: one clock, clk; reset is rst, synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Accumulators and counters are cleared.
- Reset mid-operation: the sequence aborts and no further controller writes are issued.
- Settings bus:
  - set_stb, set_addr and set_data are registered.
  - Each host write appears on the outputs exactly 1 cycle after its host_stb, with no alteration.
  - The host always wins. If the controller has a write pending in the same cycle as host_stb, the controller write is held and retried on the next cycle without host_stb.
- States:
  - IDLE: on start, go to CLR_I and set busy=1. start is ignored in every other state.
  - CLR_I: issue write of BASE+3 with data 0, then go to CLR_Q.
  - CLR_Q: issue write of BASE+4 with data 0, then go to SETTLE.
  - SETTLE: count SETTLE clk cycles, independent of run, then go to ACCUM with the accumulators zeroed.
  - ACCUM:
    - On each cycle with run=1, acc_i += sext(i_in) and acc_q += sext(q_in), and the sample counter increments.
    - Cycles with run=0 are ignored; accumulation pauses and does not abort.
    - After 2^LOG2_N accepted samples, go to WR_I.
  - WR_I: write BASE+3 with data = sext32(sat24(-mean_i)), then go to WR_Q.
  - WR_Q: write BASE+4 with data = sext32(sat24(-mean_q)), then go to DONE.
  - DONE: done=1 for one cycle, busy drops to 0 in the same cycle as the transition, then go to IDLE.
- "Issue write" means the write is presented once on the merged bus. The state advances only after the controller write has actually been emitted (host deferral included).
- Arithmetic:
  - Accumulator width is 24+LOG2_N; it cannot overflow.
  - mean = acc >>> LOG2_N (arithmetic shift, floor).
  - dc_i and dc_q are updated with the means on entry to WR_I and hold until the next completed calibration.
  - Negation saturates: mean = -8388608 gives correction +8388607. All other values are exact.
- Latency, with no host traffic and run held at 1:
  - done occurs 2 + SETTLE + 2^LOG2_N + 3 cycles after start, ±1 cycle for the registered output stage.
  - The exact value is fixed by the implementation and documented in its header.

Test Plan:
- Basic measurement: LOG2_N=4, SETTLE=4, run=1, i_in=0x000100 constant, q_in=0xFFFF00 constant, pulse start -> bus shows (BASE+3,0), (BASE+4,0), then (BASE+3,0xFFFFFF00), (BASE+4,0x00000100); done pulses once; dc_i=0x000100, dc_q=0xFFFF00; busy high throughout.
- Host collision: assert host_stb with addr 0x20, data 0xDEADBEEF in the cycle the WR_I write is due -> bus shows the host write first, the WR_I write on the next cycle, and no write lost or duplicated.
- Run gating: toggle run 1/0 every cycle during ACCUM -> still exactly 16 samples taken; same written values as the basic case; done delayed by about 16 cycles.
- Floor and saturation: i_in alternating 0x000003/0x000002 -> mean 2 and written data 0xFFFFFFFE. q_in=0x800000 constant -> dc_q=0x800000 and written data 0x007FFFFF.
- Reset during ACCUM: rst for 1 cycle -> all outputs 0 on the next cycle, no WR_I/WR_Q writes appear, busy=0, and a subsequent start runs a full clean calibration.
- Start while busy: extra start pulses during SETTLE and ACCUM -> ignored; exactly one write sequence and one done pulse.
